// File: rtl/ra_sample_tx.sv
// Sample transmitter: buffers producer samples in a small FIFO and replays each one
// on a parallel bus framed by a slow strobe with guaranteed setup/hold margins.
module ra_sample_tx #(
    parameter int BITS_PER_ELEM = 5,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int HIGH_CYCLES   = 2,
    parameter int LOW_CYCLES    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic [BITS_PER_ELEM-1:0]      s_data,
    output logic                          s_ready,
    output logic [BITS_PER_ELEM-1:0]      o_data,
    output logic                          o_data_clk,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    tx_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CW     = PTR_W + 1;
    localparam int MAX_PH = (SETUP_CYCLES > HIGH_CYCLES)
                          ? ((SETUP_CYCLES > LOW_CYCLES) ? SETUP_CYCLES : LOW_CYCLES)
                          : ((HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES);
    localparam int CNT_W  = $clog2(MAX_PH + 1);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [BITS_PER_ELEM-1:0]   mem [FIFO_DEPTH];
    logic                       push, pop;
    logic                       strobe_nxt, tx_inc;

    // Ready comes only from the registered count, so a full FIFO never accepts in a pop cycle.
    assign s_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    assign busy    = (state != IDLE) || (fifo_count != '0);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pop        = 1'b0;
        strobe_nxt = o_data_clk;
        tx_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = CNT_W'(SETUP_CYCLES);
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(1)) begin
                    strobe_nxt = 1'b1;
                    tx_inc     = 1'b1;
                    state_nxt  = HIGH;
                    cnt_nxt    = CNT_W'(HIGH_CYCLES);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt == CNT_W'(1)) begin
                    strobe_nxt = 1'b0;
                    state_nxt  = LOW;
                    cnt_nxt    = CNT_W'(LOW_CYCLES);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            LOW: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                strobe_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            o_data     <= '0;
            o_data_clk <= 1'b0;
            tx_count   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            o_data_clk <= strobe_nxt;
            if (tx_inc)
                tx_count <= tx_count + 8'd1;
            if (pop) begin
                o_data <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

endmodule
